// File: rtl/timer_prescaler.sv
// Count-tick generator for TCNT: a power-of-two divide of pclk or synchronised
// external clock edges, steered into single-cycle up/down tick pulses.
module timer_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             en,
   input  logic             dir,
   input  logic [2:0]       cks,
   input  logic             div_clr,
   input  logic             ext_clk,
   output logic             up_tick,
   output logic             dn_tick,
   output logic [PRE_W-1:0] div_val
);

   localparam logic [2:0] CKS_EXT = 3'b111;

   logic [2:0]       cks_q;
   logic [2:0]       sync_q;   // {s3, s2, s1}
   logic [PRE_W-1:0] div, div_nxt, div_max;
   logic             ext_mode, cks_chg, ext_rise, tick;

   assign ext_mode = (cks_q == CKS_EXT);
   assign cks_chg  = (cks != cks_q);
   assign ext_rise = sync_q[1] & ~sync_q[2];
   assign div_val  = div;

   // Terminal count N-1 for the registered ratio; only consulted when cks is stable.
   always_comb begin
      div_max = '0;
      case (cks_q)
         3'd0:    div_max = PRE_W'(1);
         3'd1:    div_max = PRE_W'(3);
         3'd2:    div_max = PRE_W'(7);
         3'd3:    div_max = PRE_W'(15);
         3'd4:    div_max = PRE_W'(31);
         3'd5:    div_max = PRE_W'(63);
         3'd6:    div_max = PRE_W'(127);
         default: div_max = '0;
      endcase
   end

   // Clear and ratio change outrank everything; en=0 freezes div so no partial period is lost.
   always_comb begin
      div_nxt = div;
      tick    = 1'b0;
      if (div_clr) begin
         div_nxt = '0;
      end else if (cks_chg) begin
         div_nxt = '0;
      end else if (ext_mode) begin
         div_nxt = '0;
         tick    = ext_rise & en;
      end else if (en) begin
         if (div == div_max) begin
            div_nxt = '0;
            tick    = 1'b1;
         end else begin
            div_nxt = div + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         cks_q   <= '0;
         sync_q  <= '0;
         div     <= '0;
         up_tick <= 1'b0;
         dn_tick <= 1'b0;
      end else begin
         cks_q   <= cks;
         sync_q  <= {sync_q[1:0], ext_clk};
         div     <= div_nxt;
         up_tick <= tick & ~dir;
         dn_tick <= tick & dir;
      end
   end

endmodule

// File: tb/tb_timer_prescaler.sv
// Scoreboard bench for timer_prescaler: stimulus queues expected tick edges,
// a negedge monitor pops and compares whenever a tick is presented.
module tb_timer_prescaler;

   logic       pclk = 1'b0;
   logic       preset_n = 1'b0;
   logic       en = 1'b0, dir = 1'b0, div_clr = 1'b0, ext_clk = 1'b0;
   logic [2:0] cks = 3'd0;
   logic       up_tick, dn_tick;
   logic [7:0] div_val;

   timer_prescaler #(.PRE_W(8)) dut (
      .pclk(pclk), .preset_n(preset_n), .en(en), .dir(dir), .cks(cks),
      .div_clr(div_clr), .ext_clk(ext_clk),
      .up_tick(up_tick), .dn_tick(dn_tick), .div_val(div_val)
   );

   always #5 pclk = ~pclk;

   // Count of rising edges so far; a tick registered at edge c is seen at the negedge where cyc==c.
   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      logic dn;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_tick(input int c, input logic d);
      exp_t e;
      e.cyc = c;
      e.dn  = d;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge pclk);
   endtask

   always @(negedge pclk) begin
      exp_t e;
      if (up_tick || dn_tick) begin
         check("tick_excl", int'(up_tick & dn_tick), 0);
         if (sb.size() == 0) begin
            check("unexpected_tick", cyc, -1);
         end else begin
            e = sb.pop_front();
            check("tick_cyc", cyc, e.cyc);
            check("tick_dir", int'(dn_tick), int'(e.dn));
         end
      end
   end

   initial begin
      int p, r, k, q, e;
      step(2);
      check("rst_div", int'(div_val), 0);
      check("rst_up", int'(up_tick), 0);
      check("rst_dn", int'(dn_tick), 0);
      preset_n = 1'b1;
      step(1);

      // /2 up count: 100 ticks, two edges apart
      p = cyc;
      for (int j = 1; j <= 100; j++) expect_tick(p + 2 * j, 1'b0);
      en = 1'b1;
      step(200);
      en = 1'b0;
      check("p1_div_end", int'(div_val), 0);

      // /4 stop and resume
      cks = 3'd1;
      step(1);
      check("p2_chg_div", int'(div_val), 0);
      p = cyc;
      expect_tick(p + 4, 1'b0);
      en = 1'b1;
      step(6);
      en = 1'b0;
      check("p2_hold_start", int'(div_val), 2);
      step(200);
      check("p2_hold_end", int'(div_val), 2);
      r = cyc;
      expect_tick(r + 2, 1'b0);
      expect_tick(r + 6, 1'b0);
      expect_tick(r + 10, 1'b0);
      en = 1'b1;
      step(10);
      en = 1'b0;
      check("p2_div_end", int'(div_val), 0);

      // /8 div_clr mid-period, then a clear exactly on the wrap cycle
      cks = 3'd2;
      step(1);
      p = cyc;
      en = 1'b1;
      step(5);
      check("p3_div5", int'(div_val), 5);
      div_clr = 1'b1;
      step(1);
      div_clr = 1'b0;
      check("p3_clr", int'(div_val), 0);
      k = cyc;
      expect_tick(k + 8, 1'b0);
      step(15);
      check("p3_div7", int'(div_val), 7);
      div_clr = 1'b1;
      step(1);
      div_clr = 1'b0;
      en = 1'b0;
      check("p3_clr_wrap", int'(div_val), 0);

      // /128 at 100 switched to /2
      cks = 3'd6;
      step(1);
      p = cyc;
      en = 1'b1;
      step(100);
      check("p4_div100", int'(div_val), 100);
      cks = 3'd0;
      step(1);
      check("p4_switch", int'(div_val), 0);
      expect_tick(p + 103, 1'b0);
      expect_tick(p + 105, 1'b0);
      expect_tick(p + 107, 1'b0);
      step(6);
      en = 1'b0;

      // External down count, then the same edges with en low
      dir = 1'b1;
      cks = 3'd7;
      step(1);
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         e = cyc;
         expect_tick(e + 3, 1'b1);
         ext_clk = 1'b1;
         step(4);
         ext_clk = 1'b0;
         step(4);
      end
      check("p5_div_ext", int'(div_val), 0);
      step(4);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ext_clk = 1'b1;
         step(4);
         ext_clk = 1'b0;
         step(4);
      end
      step(4);

      // Async reset with a tick showing, then with a wrap pending
      dir = 1'b0;
      cks = 3'd0;
      step(1);
      p = cyc;
      expect_tick(p + 2, 1'b0);
      expect_tick(p + 4, 1'b0);
      en = 1'b1;
      step(4);
      #1 preset_n = 1'b0;
      #1;
      check("p6_rst_up", int'(up_tick), 0);
      check("p6_rst_dn", int'(dn_tick), 0);
      check("p6_rst_div", int'(div_val), 0);
      step(1);
      preset_n = 1'b1;
      q = cyc;
      expect_tick(q + 2, 1'b0);
      step(3);
      check("p6_pending", int'(div_val), 1);
      #1 preset_n = 1'b0;
      #1;
      check("p6_rst2_div", int'(div_val), 0);
      check("p6_rst2_up", int'(up_tick), 0);
      step(1);
      en = 1'b0;
      preset_n = 1'b1;
      step(3);

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/timer_prescaler.md
# timer_prescaler

Count-tick generator that sits directly upstream of the timer counter (TCNT). It turns the control fields held in TCR (count enable, direction, clock select) into single-cycle `up_tick` / `dn_tick` pulses that the counter consumes. Ticks come from either a programmable power-of-two divide of `pclk` or from synchronised rising edges of an external clock pin. The divider freezes, rather than clears, when counting is stopped, so a stop/resume sequence loses no partial period.

## Interface
- `PRE_W`, default 8: divider register width. Must be ≥ 7 so that the largest divide ratio (/128) fits.
- `pclk`  in  1: APB/timer clock. All state is on its rising edge.
- `preset_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable (TCR[4]), registered by the upstream register file.
- `dir`  in  1: 0 = count up, 1 = count down (TCR[5]).
- `cks`  in  3: clock select (TCR[2:0]).
- `div_clr`  in  1: single-cycle pulse from the register file on a TCNT write. Restarts the current period.
- `ext_clk`  in  1: external count clock, asynchronous to `pclk`.
- `up_tick`  out  1: one-cycle increment request to the counter.
- `dn_tick`  out  1: one-cycle decrement request to the counter.
- `div_val`  out  PRE_W: current divider value, for debug and verification.

## Operation
- **Divide ratio:** for `cks` = 000..110, N = 2^(cks+1), giving 2, 4, 8, 16, 32, 64 or 128. `cks` = 111 selects external mode.
- **Internal mode, en=1:**
  - `div` increments each cycle.
  - When `div` = N-1 it wraps to 0 and a tick is raised.
- **Internal mode, en=0:**
  - `div` holds its value and no tick is raised.
  - On resume, the period continues from the held value.
- **External mode:**
  - `ext_clk` passes through a 2-flop synchroniser (s1, s2) followed by a third flop s3.
  - A rising edge is detected as s2 & ~s3.
  - A detected edge with en=1 raises a tick. Edges seen while en=0 are discarded, not queued.
  - `div` holds at 0 in this mode.
- **Tick steering:** a tick drives `up_tick` when dir=0 and `dn_tick` when dir=1. The two outputs are never high together.
- **cks change:** `cks` is registered as `cks_q`. In any cycle where `cks` ≠ `cks_q`, `div` is cleared to 0 and the tick is suppressed.
- **Priority, highest first:**
  1. `div_clr` (clears `div`, suppresses the tick)
  2. cks change
  3. en=0 hold
  4. normal count

## Timing
- **Reset values:** `div`=0, `cks_q`=000, s1/s2/s3=0, `up_tick`=0, `dn_tick`=0, `div_val`=0.
- **Registered outputs:** ticks are registered. A tick is high in the cycle after the edge at which `div` wrapped.
- **First tick:** with `div`=0 and en sampled high at edge k, the first tick is high during cycle k+N. Later ticks are exactly N cycles apart.
- **Stop/resume:** if en is low for M cycles mid-period, the next tick is delayed by exactly M cycles.
- **div_clr:** a pulse at edge k gives `div`=0 after k. The next tick is at k+N+1 when en stays high.
- **External latency:** a tick appears 3 `pclk` cycles after the first `pclk` edge that samples `ext_clk` high.
  - `ext_clk` high and low phases must each be ≥ 2 `pclk` periods.
  - Faster inputs may lose edges. This is by design and is not flagged.
- **dir change:** takes effect on the next tick. It does not disturb `div`.
- **Reset mid-period:** asynchronous. Outputs drop to 0 immediately. The first post-reset tick follows the first-tick rule above.
- **Wrap:** `div` never exceeds N-1. Values outside 0..N-1 are unreachable, because `div` is cleared on every `cks` change.

## Test plan
- **/2 up count:** reset, cks=000, dir=0, en=1 for 200 cycles → exactly 100 `up_tick` pulses, 2 cycles apart, `dn_tick` stuck at 0.
- **Stop/resume:** cks=001 (/4), en=1 for 6 cycles, en=0 for 200 cycles, en=1 again → `div_val` holds at 2 throughout the stop. The next tick comes 2 cycles after resume, then every 4 cycles.
- **div_clr mid-period:** cks=010 (/8), `div_val`=5, pulse `div_clr` → `div_val`=0 next cycle, no tick, next tick 9 cycles after the pulse edge.
- **cks switch:** running /128 at `div_val`=100, switch to cks=000 → `div_val`=0, no spurious tick, then ticks every 2 cycles.
- **External down count:** cks=111, dir=1, en=1, `ext_clk` period 8 `pclk` for 10 rising edges → 10 `dn_tick` pulses, each 3 cycles after its edge is sampled. The same edges with en=0 → 0 ticks.
- **Async reset:** assert `preset_n` low mid-period with a tick pending → `up_tick`, `dn_tick` and `div_val` are 0 before the next `pclk` edge.
